fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage, directly upstream of the combinational 16K-word instruction memory. It owns the 14-bit program counter, drives the memory's `PC` address, and captures the returned 32-bit word into an IF/ID pipeline register that the decoder consumes through a valid/ready handshake. It also handles stall, control-flow redirect with flush, and halt/resume.

## Interface
- `RESET_PC`, 14'd0, PC value loaded on reset.
- `NOP_WORD`, 32'h0000_0000, word placed in `if_ir` on reset and on flush.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `pc_o`  out  14  address to instruction memory (`PC`); equals the internal PC register.
- `ir_i`  in  32  instruction word from memory (`IR`); valid combinationally in the same cycle as `pc_o`.
- `id_ready`  in  1  decoder accepts `if_ir` this cycle.
- `redirect_valid`  in  1  branch/jump taken; flush and reload the PC.
- `redirect_pc`  in  14  target address, sampled when `redirect_valid`=1.
- `halt_req`  in  1  stop fetching after this cycle.
- `if_valid`  out  1  `if_ir`/`if_pc` hold a live instruction.
- `if_ir`  out  32  fetched instruction (IF/ID register).
- `if_pc`  out  14  address the `if_ir` word was fetched from.
- `halted`  out  1  FSM is in HALTED.

## Operation
- FSM states: BOOT, RUN, HALTED. Reset → BOOT. BOOT → RUN unconditionally after 1 cycle; no fetch occurs in BOOT.
- Fetch enable `fe` = (state==RUN) && (!if_valid || id_ready).
- Per rising edge, priority high to low:
  1. `!rst_n`: pc=RESET_PC, state=BOOT, if_valid=0, if_ir=NOP_WORD, if_pc=0.
  2. `redirect_valid`: pc=redirect_pc, if_valid=0, if_ir=NOP_WORD. The word currently in the IF/ID register is discarded even if `id_ready`=1 in the same cycle. State goes to RUN, or to HALTED if `halt_req`=1 in the same cycle. From BOOT, the state still moves to RUN.
  3. `fe`: if_ir=ir_i, if_pc=pc, if_valid=1, pc=pc+1 modulo 2^14, so 14'h3FFF wraps to 14'h0000.
  4. Not `fe` and `id_ready`: if_valid=0, so the word is consumed with no replacement. Registers otherwise hold.
  5. Otherwise all registers hold. This is the stall case: `if_valid`=1 and `id_ready`=0.
- `halt_req` in RUN without redirect → HALTED at the next edge. A fetch in that same cycle still completes when `fe`=1. In HALTED no fetch occurs; a pending `if_valid` word stays until `id_ready` consumes it.
- HALTED is left only by `redirect_valid` (→ RUN at redirect_pc) or by reset. `halt_req` in HALTED has no effect.
- Throughput: 1 instruction/cycle while `id_ready`=1 and there is no redirect.

## Timing
- Reset values: `pc_o`=RESET_PC, `if_valid`=0, `if_ir`=NOP_WORD, `if_pc`=0, `halted`=0.
- First fetch: the edge after BOOT. The first `if_valid`=1 appears 2 edges after `rst_n` deasserts.
- Fetch latency: the `ir_i` word sampled at edge N is presented on `if_ir` after edge N, i.e. 1 cycle.
- Redirect penalty: `if_valid`=0 for exactly 1 cycle after the redirect edge. The target word is on `if_ir` after the following edge.
- `halted` is registered; it asserts 1 cycle after `halt_req` is accepted.
- Reset asserted mid-stall or mid-halt overrides everything on that edge.
- The handshake requires `if_ir`/`if_pc` to be stable while `if_valid`=1 and `id_ready`=0.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, two extra outputs are compiled in:
  - `perf_fetched` [31:0] increments on each `fe` edge.
  - `perf_stall` [31:0] increments on each RUN-state edge with `if_valid`=1, `id_ready`=0, and no redirect.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- Reset release, `id_ready`=1, memory words 0..6 preloaded → `if_valid` rises 2 edges after reset, then `if_pc`=0,1,2… on consecutive cycles with `if_ir`=mem[n].
- Hold `id_ready`=0 for 3 cycles while `if_pc`=2 → `if_ir`/`if_pc`/`pc_o` frozen (2 / 3); fetch resumes with pc 3 after release, with no word lost or duplicated.
- `redirect_valid`=1, `redirect_pc`=14'd100 while `if_pc`=4 valid and `id_ready`=1 → next cycle `if_valid`=0 and `if_ir`=NOP_WORD; the following cycle `if_pc`=100.
- Redirect to 14'h3FFE → `if_pc` sequence 3FFE, 3FFF, 0000.
- `halt_req` pulse at pc 5 → `halted`=1 next cycle and `pc_o` stays 6; a redirect to 20 returns to RUN, `halted`=0, and `if_pc`=20 follows. `halt_req` asserted together with the redirect → `halted`=1 with `pc_o`=20.
- With `FETCH_PERF_CNT_EN`: 10 fetches plus a 3-cycle stall → `perf_fetched`=10, `perf_stall`=3; reset mid-run → both counters 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
// Owns the 14-bit PC, presents it to the combinational instruction memory,
// captures the returned word, and hands it to decode over valid/ready.
// Handles stall, redirect with flush, and halt/resume.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
//
// state  | meaning
// -------+--------------------------------------------------------------
// BOOT   | one cycle after reset, no fetch
// RUN    | fetching, one word per cycle when decode keeps up
// HALTED | no fetch; pending word drains; left only by redirect or reset
module fetch_unit #(
  parameter logic [13:0] RESET_PC = 14'd0,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [13:0] pc_o,
  input  logic [31:0] ir_i,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [13:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [13:0] if_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_ir_q, if_ir_d;
  logic [13:0] if_pc_q, if_pc_d;
  logic        fe;

  assign fe = (state_q == RUN) && (!if_valid_q || id_ready);

  // Next-state and IF/ID register update; redirect beats fetch beats drain.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_ir_d    = if_ir_q;
    if_pc_d    = if_pc_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      // The word in IF/ID is on the wrong path; drop it even if decode would take it.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_ir_d    = NOP_WORD;
      state_d    = halt_req ? HALTED : RUN;
    end else if (fe) begin
      if_ir_d    = ir_i;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 14'd1;
    end else if (id_ready) begin
      if_valid_d = 1'b0;
    end
  end

  // State, PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_ir_q    <= NOP_WORD;
      if_pc_q    <= 14'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_ir_q    <= if_ir_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign if_valid = if_valid_q;
  assign if_ir    = if_ir_q;
  assign if_pc    = if_pc_q;
  assign halted   = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count words actually captured and RUN cycles where decode back-pressures.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (fe && !redirect_valid)
      perf_fetched_d = perf_fetched_q + 32'd1;
    if ((state_q == RUN) && if_valid_q && !id_ready && !redirect_valid)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Instruction memory is modelled
// as word(pc) = {16'hC0DE, 2'b00, pc}, so expected words are written by hand.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] pc_o;
  logic [31:0] ir_i;
  logic        id_ready;
  logic        redirect_valid;
  logic [13:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [13:0] if_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ir_i = {16'hC0DE, 2'b00, pc_o};

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_o           (pc_o),
    .ir_i           (ir_i),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_pc          (if_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [13:0] p,
                        input logic [31:0] w, input logic [13:0] pc);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".if_pc"}, {18'd0, if_pc}, {18'd0, p});
    chk({tag, ".if_ir"}, if_ir, w);
    chk({tag, ".pc_o"},  {18'd0, pc_o}, {18'd0, pc});
  endtask

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 14'd0; halt_req = 1'b0;

    // reset state
    step();
    chk_if("rst", 1'b0, 14'd0, 32'h0, 14'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;

    // BOOT cycle: still no word
    step();
    chk("boot.valid", {31'd0, if_valid}, 32'd0);
    chk("boot.pc_o", {18'd0, pc_o}, 32'd0);

    // streaming fetch
    step(); chk_if("f0", 1'b1, 14'd0, 32'hC0DE_0000, 14'd1);
    step(); chk_if("f1", 1'b1, 14'd1, 32'hC0DE_0001, 14'd2);
    step(); chk_if("f2", 1'b1, 14'd2, 32'hC0DE_0002, 14'd3);

    // 3-cycle stall, everything frozen
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("stall", 1'b1, 14'd2, 32'hC0DE_0002, 14'd3);
    end
    id_ready = 1'b1;
    step(); chk_if("f3", 1'b1, 14'd3, 32'hC0DE_0003, 14'd4);
    step(); chk_if("f4", 1'b1, 14'd4, 32'hC0DE_0004, 14'd5);

    // redirect to 100 while word 4 is being accepted
    redirect_valid = 1'b1; redirect_pc = 14'd100;
    step();
    chk("rd.valid", {31'd0, if_valid}, 32'd0);
    chk("rd.if_ir", if_ir, 32'h0);
    chk("rd.pc_o", {18'd0, pc_o}, 32'd100);
    redirect_valid = 1'b0;
    step(); chk_if("rd.t", 1'b1, 14'd100, 32'hC0DE_0064, 14'd101);

    // redirect near top of address space, check wrap
    redirect_valid = 1'b1; redirect_pc = 14'h3FFE;
    step();
    chk("wr.valid", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0;
    step(); chk_if("wr0", 1'b1, 14'h3FFE, 32'hC0DE_3FFE, 14'h3FFF);
    step(); chk_if("wr1", 1'b1, 14'h3FFF, 32'hC0DE_3FFF, 14'h0000);
    step(); chk_if("wr2", 1'b1, 14'h0000, 32'hC0DE_0000, 14'h0001);

    // halt: fetch in the halt cycle still completes
    halt_req = 1'b1;
    step();
    chk("h.halted", {31'd0, halted}, 32'd1);
    chk_if("h", 1'b1, 14'd1, 32'hC0DE_0001, 14'd2);
    halt_req = 1'b0; id_ready = 1'b0;
    step(); chk_if("h.hold", 1'b1, 14'd1, 32'hC0DE_0001, 14'd2);
    id_ready = 1'b1; halt_req = 1'b1;
    step(); chk_if("h.drain", 1'b0, 14'd1, 32'hC0DE_0001, 14'd2);
    halt_req = 1'b0;
    step();
    chk("h.still", {31'd0, halted}, 32'd1);
    chk("h.pc", {18'd0, pc_o}, 32'd2);

    // resume by redirect to 20
    redirect_valid = 1'b1; redirect_pc = 14'd20;
    step();
    chk("rs.halted", {31'd0, halted}, 32'd0);
    chk("rs.valid", {31'd0, if_valid}, 32'd0);
    chk("rs.pc", {18'd0, pc_o}, 32'd20);
    redirect_valid = 1'b0;
    step(); chk_if("rs.t", 1'b1, 14'd20, 32'hC0DE_0014, 14'd21);

    // redirect together with halt -> halted at the target
    redirect_valid = 1'b1; redirect_pc = 14'd20; halt_req = 1'b1;
    step();
    redirect_valid = 1'b0; halt_req = 1'b0;
    chk("rh.halted", {31'd0, halted}, 32'd1);
    chk("rh.valid", {31'd0, if_valid}, 32'd0);
    chk("rh.pc", {18'd0, pc_o}, 32'd20);
    step();
    chk("rh.hold", {18'd0, pc_o}, 32'd20);

    // reset mid-halt
    rst_n = 1'b0; halt_req = 1'b1;
    step();
    chk("rh2.halted", {31'd0, halted}, 32'd0);
    chk("rh2.pc", {18'd0, pc_o}, 32'd0);
    rst_n = 1'b1; halt_req = 1'b0;

    // 10 fetches then a 3-cycle stall, then reset mid-stall
    step();
    for (int i = 0; i < 10; i++) step();
    chk_if("p10", 1'b1, 14'd9, 32'hC0DE_0009, 14'd10);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_if("p.stall", 1'b1, 14'd9, 32'hC0DE_0009, 14'd10);
`ifdef FETCH_PERF_CNT_EN
    chk("perf.fetched", perf_fetched, 32'd10);
    chk("perf.stall", perf_stall, 32'd3);
`endif
    rst_n = 1'b0;
    step();
    chk_if("rs.stall", 1'b0, 14'd0, 32'h0, 14'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf.rst.f", perf_fetched, 32'd0);
    chk("perf.rst.s", perf_stall, 32'd0);
`endif
    rst_n = 1'b1; id_ready = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
